// File: rtl/instr_fetch.sv
// IF stage plus IF/ID pipeline register: PC, imem address, jump/branch/stall/flush/halt control.
// Optional FETCH_STATS_EN adds fetch_count/bubble_count performance counters.
module instr_fetch #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [4:0]           HALT_OPCODE = 5'b11111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [1:0]          JMPSel,
    input  logic [PC_WIDTH-1:0] Address,
    input  logic [PC_WIDTH-1:0] JumpReg,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc_id,
    output logic [PC_WIDTH-1:0] pc_plus4_id,
    output logic                valid_id,
    output logic                halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         bubble_count
`endif
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_id_q, pc_id_d;
    logic [PC_WIDTH-1:0] pc4_id_q, pc4_id_d;
    logic                valid_q, valid_d;
    logic                latch_c;
    logic                jump_c;
    logic [PC_WIDTH-1:0] seq_pc_c;

    assign seq_pc_c = pc_q + PC_STEP;
    // Jumps from decode are only honoured while running.
    assign jump_c   = (state_q == ST_RUN) && ((JMPSel == 2'b01) || (JMPSel == 2'b10));

    // Next-state for IF/ID, PC and the run/halt FSM.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_id_d  = pc_id_q;
        pc4_id_d = pc4_id_q;
        valid_d  = valid_q;
        state_d  = state_q;
        latch_c  = 1'b0;

        if (BranchTaken || flush) begin
            instr_d  = '0;
            pc_id_d  = '0;
            pc4_id_d = '0;
            valid_d  = 1'b0;
        end else if (stall) begin
            valid_d  = valid_q;
        end else if (jump_c || (state_q == ST_HALTED)) begin
            instr_d  = '0;
            pc_id_d  = '0;
            pc4_id_d = '0;
            valid_d  = 1'b0;
        end else begin
            instr_d  = imem_rdata;
            pc_id_d  = pc_q;
            pc4_id_d = seq_pc_c;
            valid_d  = 1'b1;
            latch_c  = 1'b1;
        end

        if (BranchTaken) begin
            pc_d = BranchTarget & ALIGN_MASK;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jump_c) begin
            pc_d = ((JMPSel == 2'b01) ? Address : JumpReg) & ALIGN_MASK;
        end else if (state_q == ST_HALTED) begin
            pc_d = pc_q;
        end else begin
            pc_d = seq_pc_c;
        end

        // A taken EX branch proves any halt word was on the wrong path.
        if (BranchTaken) begin
            state_d = ST_RUN;
        end else if (latch_c && (imem_rdata[31:27] == HALT_OPCODE)) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_id_q  <= '0;
            pc4_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_id_q  <= pc_id_d;
            pc4_id_q <= pc4_id_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_id       = pc_id_q;
    assign pc_plus4_id = pc4_id_q;
    assign valid_id    = valid_q;
    assign halted      = (state_q == ST_HALTED);

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Bubble count covers every non-reset cycle that leaves IF/ID invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (latch_c) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!valid_d) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule
